sdram_dispatch_w: RTL and testbench
===================================

Name: sdram_dispatch_w

Overview:
Write-side channel dispatcher for the SDRAM read-back path. It accepts a burst request tagged with a channel index (0..NUM_CH-1), then steers the burst's data words into that channel's write FIFO. It throttles on the selected channel's full flag and counts words to burst completion. It is the demultiplexing counterpart of the read-side ready selector: that block reports which channel can accept data; this block delivers the data to that channel.

Parameters:
NUM_CH, 20, number of channel FIFOs served (1..256)
CH_W, 8, width of channel index
DATA_W, 16, SDRAM data word width
LEN_W, 9, width of burst length field (max burst 2^LEN_W - 1 words)

Ports:
clk  in  1  system clock; all logic rising-edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  burst request valid
req_channel  in  CH_W  target channel index
req_len  in  LEN_W  burst length in words
req_ready  out  1  request accepted when req_valid && req_ready
in_valid  in  1  data word valid from SDRAM read path
in_data  in  DATA_W  data word
in_ready  out  1  data word consumed when in_valid && in_ready
ch_full  in  NUM_CH  per-channel FIFO full flags (bit n = channel n)
ch_wr_en  out  NUM_CH  per-channel FIFO write enable, one-hot or zero
ch_wr_data  out  DATA_W  write data, shared by all channel FIFOs
busy  out  1  burst in progress
done  out  1  one-cycle pulse, burst complete
err  out  1  one-cycle pulse, request rejected

Behaviour:
- Reset (rst=1 at clk edge):
  - State goes to IDLE; word counter and latched channel clear to 0.
  - Registered outputs: busy=0, done=0, err=0.
  - Combinational outputs settle to: req_ready=1, in_ready=0, ch_wr_en=0.
  - Reset mid-burst abandons the burst: no further writes, no done pulse.
- States: IDLE, XFER, DONE.
- IDLE:
  - req_ready=1, in_ready=0, ch_wr_en=0.
  - On accept with req_channel >= NUM_CH or req_len == 0: err=1 on the next cycle, state stays IDLE, nothing is latched.
  - On a valid accept: latch ch_q=req_channel and cnt=req_len, then go to XFER. busy=1 from the next cycle.
- XFER:
  - req_ready=0; new requests are held off.
  - in_ready = ~ch_full[ch_q], combinational.
  - ch_wr_en[ch_q] = in_valid & in_ready, all other bits 0. ch_wr_data = in_data, combinational pass-through, zero latency.
  - Each transfer decrements cnt by 1.
  - A transfer with cnt==1 moves the state to DONE.
  - in_valid=0 or ch_full high stalls the burst indefinitely. No timeout; cnt is held.
  - ch_full may toggle mid-burst; only bit ch_q is observed. Full flags of other channels have no effect.
- DONE (exactly one cycle):
  - done=1, busy=0, req_ready=0, in_ready=0; then return to IDLE.
  - Minimum request-to-request spacing: len+2 cycles with no stalls.
- Outside XFER, ch_wr_data is don't-care and ch_wr_en must be 0.
- in_data/in_valid arriving in IDLE or DONE are not consumed (in_ready=0).
- cnt is LEN_W bits wide and never wraps: it decrements only while it is >= 1.
- Simultaneous events:
  - rst dominates all other inputs.
  - A req_valid presented in the DONE cycle is not accepted; it is accepted in the following IDLE cycle.
- done and err are never asserted in the same cycle.

Test Plan:
- Basic burst: req ch=5, len=4; 4 words 0xA001..0xA004 with in_valid continuously high, ch_full=0 -> ch_wr_en=0x00020 for exactly 4 cycles carrying those words in order; done pulses one cycle later; busy high for 4 cycles.
- Backpressure: ch=19, len=3; ch_full[19]=1 for cycles 2-4 of XFER -> in_ready=0 and no writes during the stall; all 3 words written afterward in order; ch_full[0..18] toggling has no effect.
- Rejection: req ch=20 (NUM_CH=20), then ch=3 with len=0 -> err pulses once per request; req_ready stays 1; busy, ch_wr_en and done stay 0.
- Back-to-back: req ch=0 len=1 held valid, second req ch=1 len=2 presented during DONE -> second request accepted only on the IDLE cycle after DONE; writes go to bit0 then bit1; two done pulses.
- Reset mid-burst: ch=7 len=10; assert rst after 4 words -> next cycle ch_wr_en=0, busy=0, req_ready=1, no done pulse; a fresh req ch=7 len=2 then completes normally.
- Idle data ignored: in_valid=1 with req_valid=0 for 5 cycles -> in_ready=0 and ch_wr_en=0 throughout.

Source files
------------

// File: rtl/sdram_dispatch_w.sv
// Write-side channel dispatcher: steers a tagged burst of SDRAM data words into one
// channel FIFO, throttling on that channel's full flag and counting words to completion.
module sdram_dispatch_w #(
    parameter int NUM_CH = 20,
    parameter int CH_W   = 8,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 9
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    input  logic [CH_W-1:0]   req_channel_i,
    input  logic [LEN_W-1:0]  req_len_i,
    output logic              req_ready_o,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              in_ready_o,
    input  logic [NUM_CH-1:0] ch_full_i,
    output logic [NUM_CH-1:0] ch_wr_en_o,
    output logic [DATA_W-1:0] ch_wr_data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);
    // state | meaning
    // IDLE  | waiting for a burst request
    // XFER  | moving words into FIFO ch_q, cnt_q words left
    // DONE  | one-cycle completion pulse, requests held off
    typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, DONE = 2'd2} state_t;

    state_t             state_q;
    logic [CH_W-1:0]    ch_q;
    logic [LEN_W-1:0]   cnt_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;
    logic [NUM_CH-1:0]  ch_sel;
    logic               xfer_fire;
    logic               req_bad;

    // One-hot decode of the latched channel avoids a width-mismatched bit select.
    always_comb begin
        ch_sel = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            ch_sel[n] = (ch_q == CH_W'(n));
        end
    end

    assign req_ready_o  = (state_q == IDLE);
    assign in_ready_o   = (state_q == XFER) && ((ch_full_i & ch_sel) == '0);
    assign xfer_fire    = in_valid_i && in_ready_o;
    assign ch_wr_en_o   = xfer_fire ? ch_sel : '0;
    assign ch_wr_data_o = in_data_i;
    assign req_bad      = (32'(req_channel_i) >= 32'(NUM_CH)) || (req_len_i == '0);

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign err_o  = err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ch_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        if (req_bad) begin
                            err_q <= 1'b1;
                        end else begin
                            ch_q    <= req_channel_i;
                            cnt_q   <= req_len_i;
                            busy_q  <= 1'b1;
                            state_q <= XFER;
                        end
                    end
                end
                XFER: begin
                    if (xfer_fire && (cnt_q != '0)) begin
                        cnt_q <= cnt_q - LEN_W'(1);
                        if (cnt_q == LEN_W'(1)) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sdram_dispatch_w.sv
// Directed bench for sdram_dispatch_w: per-cycle vector table plus a long randomly
// stalled burst checked against a word-order scoreboard.
module tb_sdram_dispatch_w;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic [7:0]  req_channel_i;
    logic [8:0]  req_len_i;
    logic        req_ready_o;
    logic        in_valid_i;
    logic [15:0] in_data_i;
    logic        in_ready_o;
    logic [19:0] ch_full_i;
    logic [19:0] ch_wr_en_o;
    logic [15:0] ch_wr_data_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    int checks = 0;
    int errors = 0;

    sdram_dispatch_w #(.NUM_CH(20), .CH_W(8), .DATA_W(16), .LEN_W(9)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_channel_i(req_channel_i), .req_len_i(req_len_i),
        .req_ready_o(req_ready_o),
        .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_ready_o(in_ready_o),
        .ch_full_i(ch_full_i), .ch_wr_en_o(ch_wr_en_o), .ch_wr_data_o(ch_wr_data_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int rst, rv, ch, len, iv, d, full;
        int rr, ir, wen, busy, done, err;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(int rst, int rv, int ch, int len, int iv, int d, int full,
                                int rr, int ir, int wen, int busy, int done, int err);
        vec_t v;
        v.rst = rst; v.rv = rv; v.ch = ch; v.len = len; v.iv = iv; v.d = d; v.full = full;
        v.rr = rr; v.ir = ir; v.wen = wen; v.busy = busy; v.done = done; v.err = err;
        return v;
    endfunction

    function automatic int bit_of(int n);
        return 1 << n;
    endfunction

    task automatic chk(input string nm, input int idx, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s step %0d actual %h required %h", nm, idx, act, req);
        end
    endtask

    initial begin
        int written;
        bit got_done;
        logic full_bit;
        logic iv_bit;
        logic [19:0] fullv;

        rst_i = 1'b1; req_valid_i = 1'b0; req_channel_i = '0; req_len_i = '0;
        in_valid_i = 1'b0; in_data_i = '0; ch_full_i = '0;

        // rst rv ch len iv data full | rr ir wen busy done err
        // reset state
        vq.push_back(mk(0,0,0,0, 0,0,0,              1,0,0,0,0,0));
        // basic burst ch5 len4, idle data offered during DONE is not taken
        vq.push_back(mk(0,1,5,4, 0,0,0,              1,0,0,0,0,0));
        vq.push_back(mk(0,0,0,0, 1,'hA001,0,         0,1,bit_of(5),1,0,0));
        vq.push_back(mk(0,0,0,0, 1,'hA002,0,         0,1,bit_of(5),1,0,0));
        vq.push_back(mk(0,0,0,0, 1,'hA003,0,         0,1,bit_of(5),1,0,0));
        vq.push_back(mk(0,0,0,0, 1,'hA004,0,         0,1,bit_of(5),1,0,0));
        vq.push_back(mk(0,0,0,0, 1,'hA005,0,         0,0,0,0,1,0));
        vq.push_back(mk(0,0,0,0, 0,0,0,              1,0,0,0,0,0));
        // backpressure ch19 len3, other full bits toggle
        vq.push_back(mk(0,1,19,3, 0,0,0,             1,0,0,0,0,0));
        vq.push_back(mk(0,0,0,0, 1,'hB001,'h00AAA,   0,1,bit_of(19),1,0,0));
        vq.push_back(mk(0,0,0,0, 1,'hB002,'h80AAA,   0,0,0,1,0,0));
        vq.push_back(mk(0,0,0,0, 1,'hB002,'h85555,   0,0,0,1,0,0));
        vq.push_back(mk(0,0,0,0, 1,'hB002,'h80000,   0,0,0,1,0,0));
        vq.push_back(mk(0,0,0,0, 0,'hB002,0,         0,1,0,1,0,0));
        vq.push_back(mk(0,0,0,0, 1,'hB002,'h7FFFF,   0,1,bit_of(19),1,0,0));
        vq.push_back(mk(0,0,0,0, 1,'hB003,'h2AAAA,   0,1,bit_of(19),1,0,0));
        vq.push_back(mk(0,0,0,0, 0,0,0,              0,0,0,0,1,0));
        vq.push_back(mk(0,0,0,0, 0,0,0,              1,0,0,0,0,0));
        // rejections: channel out of range, zero length
        vq.push_back(mk(0,1,20,5, 0,0,0,             1,0,0,0,0,0));
        vq.push_back(mk(0,1,3,0, 0,0,0,              1,0,0,0,0,1));
        vq.push_back(mk(0,0,0,0, 0,0,0,              1,0,0,0,0,1));
        vq.push_back(mk(0,0,0,0, 0,0,0,              1,0,0,0,0,0));
        // back-to-back: second request in DONE waits for IDLE
        vq.push_back(mk(0,1,0,1, 0,0,0,              1,0,0,0,0,0));
        vq.push_back(mk(0,1,0,1, 1,'hC001,0,         0,1,bit_of(0),1,0,0));
        vq.push_back(mk(0,1,1,2, 1,'hC002,0,         0,0,0,0,1,0));
        vq.push_back(mk(0,1,1,2, 1,'hC002,0,         1,0,0,0,0,0));
        vq.push_back(mk(0,0,0,0, 1,'hC002,0,         0,1,bit_of(1),1,0,0));
        vq.push_back(mk(0,0,0,0, 1,'hC003,0,         0,1,bit_of(1),1,0,0));
        vq.push_back(mk(0,0,0,0, 0,0,0,              0,0,0,0,1,0));
        vq.push_back(mk(0,0,0,0, 0,0,0,              1,0,0,0,0,0));
        // reset mid-burst ch7 len10, reset also overrides a request
        vq.push_back(mk(0,1,7,10, 0,0,0,             1,0,0,0,0,0));
        vq.push_back(mk(0,0,0,0, 1,'hD001,0,         0,1,bit_of(7),1,0,0));
        vq.push_back(mk(0,0,0,0, 1,'hD002,0,         0,1,bit_of(7),1,0,0));
        vq.push_back(mk(0,0,0,0, 1,'hD003,0,         0,1,bit_of(7),1,0,0));
        vq.push_back(mk(0,0,0,0, 1,'hD004,0,         0,1,bit_of(7),1,0,0));
        vq.push_back(mk(1,1,7,2, 0,0,0,              0,1,0,1,0,0));
        vq.push_back(mk(0,0,0,0, 1,'hD005,0,         1,0,0,0,0,0));
        vq.push_back(mk(0,0,0,0, 0,0,0,              1,0,0,0,0,0));
        vq.push_back(mk(0,1,7,2, 0,0,0,              1,0,0,0,0,0));
        vq.push_back(mk(0,0,0,0, 1,'hE001,0,         0,1,bit_of(7),1,0,0));
        vq.push_back(mk(0,0,0,0, 1,'hE002,0,         0,1,bit_of(7),1,0,0));
        vq.push_back(mk(0,0,0,0, 0,0,0,              0,0,0,0,1,0));
        // idle data is ignored
        for (int k = 0; k < 5; k++)
            vq.push_back(mk(0,0,0,0, 1,'hF000 + k,'h5A5A5 >> k, 1,0,0,0,0,0));

        repeat (2) @(posedge clk_i);
        #1;
        for (int i = 0; i < vq.size(); i++) begin
            rst_i         = 1'(vq[i].rst);
            req_valid_i   = 1'(vq[i].rv);
            req_channel_i = 8'(vq[i].ch);
            req_len_i     = 9'(vq[i].len);
            in_valid_i    = 1'(vq[i].iv);
            in_data_i     = 16'(vq[i].d);
            ch_full_i     = 20'(vq[i].full);
            #2;
            chk("req_ready", i, int'(req_ready_o), vq[i].rr);
            chk("in_ready",  i, int'(in_ready_o),  vq[i].ir);
            chk("ch_wr_en",  i, int'(ch_wr_en_o),  vq[i].wen);
            chk("busy",      i, int'(busy_o),      vq[i].busy);
            chk("done",      i, int'(done_o),      vq[i].done);
            chk("err",       i, int'(err_o),       vq[i].err);
            if (vq[i].wen != 0)
                chk("ch_wr_data", i, int'(ch_wr_data_o), vq[i].d);
            @(posedge clk_i);
            #1;
        end

        // long burst on ch12 with random stalls and noisy neighbour full flags
        rst_i = 1'b0; req_valid_i = 1'b1; req_channel_i = 8'd12; req_len_i = 9'd300;
        in_valid_i = 1'b0; ch_full_i = '0;
        #2;
        chk("long_req_ready", 0, int'(req_ready_o), 1);
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        written  = 0;
        got_done = 1'b0;
        for (int c = 0; c < 3000 && !got_done; c++) begin
            full_bit = ($urandom_range(0, 4) == 0);
            iv_bit   = ($urandom_range(0, 3) != 0);
            fullv    = 20'($urandom());
            fullv[12] = full_bit;
            in_valid_i = iv_bit;
            in_data_i  = 16'h1000 + 16'(written);
            ch_full_i  = fullv;
            #2;
            if (done_o) begin
                got_done = 1'b1;
                chk("long_word_count", c, written, 300);
                chk("long_done_wen", c, int'(ch_wr_en_o), 0);
            end else begin
                chk("long_in_ready", c, int'(in_ready_o), int'(!full_bit));
                chk("long_busy", c, int'(busy_o), 1);
                if (iv_bit && !full_bit) begin
                    chk("long_wen", c, int'(ch_wr_en_o), bit_of(12));
                    chk("long_data", c, int'(ch_wr_data_o), 'h1000 + written);
                    written++;
                end else begin
                    chk("long_stall_wen", c, int'(ch_wr_en_o), 0);
                end
            end
            @(posedge clk_i);
            #1;
        end
        if (!got_done) begin
            checks++;
            errors++;
            $display("FAIL long_timeout actual no done after %0d words required done after 300", written);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual still running required finished");
        $fatal(1, "watchdog expired");
    end
endmodule
